// File: rtl/secuenciador_notas.sv
// secuenciador_notas -- challenge-mode note sequence player.
//
// On a start request the block asks the sequence source to present busNotas,
// latches it, then plays each 3-bit note code for a fixed on-time followed by
// a silent gap. When playback finishes it pulses a handoff to the challenge FSM.
//
// Optional build macro: SECUENCIADOR_TEMPO_EN
//   Defined   -> adds input tempo[1:0], latched with the sequence; the note
//                on-time becomes T_NOTA >> tempo (never less than 1 cycle).
//   Undefined -> no tempo port; the on-time is always T_NOTA.
//
// Ports:
//   clk              in   system clock, rising edge
//   reset            in   asynchronous active-high reset
//   inicio           in   start request, honoured only when idle
//   abortar          in   cancel playback (wins over everything but reset)
//   busNotas         in   NUM_NOTAS slots of ANCHO_NOTA bits, slot 0 first, 0 = end marker
//   tempo            in   (SECUENCIADOR_TEMPO_EN only) on-time shift amount
//   cargarSecuencia  out  one-cycle request for the source to present busNotas
//   notaSalida       out  note code for the tone generator, 0 = silence
//   sonando          out  high while a nonzero note is driven
//   indiceNota       out  current slot index, 0..NUM_NOTAS
//   ocupado          out  high whenever the player is not idle
//   secuenciaLista   out  one-cycle pulse on normal completion
module secuenciador_notas #(
   parameter int NUM_NOTAS  = 10,
   parameter int ANCHO_NOTA = 3,
   parameter int T_NOTA     = 25000000,
   parameter int T_PAUSA    = 5000000
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            inicio,
   input  logic                            abortar,
   input  logic [NUM_NOTAS*ANCHO_NOTA-1:0] busNotas,
`ifdef SECUENCIADOR_TEMPO_EN
   input  logic [1:0]                      tempo,
`endif
   output logic                            cargarSecuencia,
   output logic [ANCHO_NOTA-1:0]           notaSalida,
   output logic                            sonando,
   output logic [3:0]                      indiceNota,
   output logic                            ocupado,
   output logic                            secuenciaLista
);

   localparam int ANCHO_BUS = NUM_NOTAS * ANCHO_NOTA;
   localparam int T_MAX     = (T_NOTA > T_PAUSA) ? T_NOTA : T_PAUSA;
   localparam int CW        = (T_MAX > 1) ? $clog2(T_MAX) : 1;

   typedef enum logic [2:0] {
      REPOSO   = 3'd0,
      SOLICITA = 3'd1,
      CAPTURA  = 3'd2,
      SONAR    = 3'd3,
      PAUSA    = 3'd4,
      FIN      = 3'd5
   } estado_t;

   estado_t                estado_q, estado_d;
   logic [ANCHO_BUS-1:0]   notas_q, notas_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [3:0]             idx_q, idx_d;
   logic                   cargar_q, cargar_d;
   logic [ANCHO_NOTA-1:0]  nota_q, nota_d;
   logic                   sonando_q, sonando_d;
   logic                   ocupado_q, ocupado_d;
   logic                   lista_q, lista_d;
   logic [3:0]             idx_sig_s;
   logic [31:0]            t_on_s;
   logic                   fin_nota_s;
   logic                   fin_pausa_s;
`ifdef SECUENCIADOR_TEMPO_EN
   logic [1:0]             tempo_q, tempo_d;
   logic [31:0]            t_shift_s;
`endif

   // Slot extraction; an index past the last slot reads as the end marker.
   function automatic logic [ANCHO_NOTA-1:0] slot_de(input logic [ANCHO_BUS-1:0] bus,
                                                     input logic [3:0] idx);
      logic [ANCHO_NOTA-1:0] r;
      r = '0;
      for (int i = 0; i < NUM_NOTAS; i++) begin
         if (idx == 4'(i)) begin
            r = bus[i*ANCHO_NOTA +: ANCHO_NOTA];
         end
      end
      return r;
   endfunction

   // Note on-time in cycles, optionally shortened by the latched tempo.
`ifdef SECUENCIADOR_TEMPO_EN
   always_comb begin
      t_shift_s = 32'(T_NOTA) >> tempo_q;
      if (t_shift_s == 32'd0) begin
         t_on_s = 32'd1;
      end else begin
         t_on_s = t_shift_s;
      end
   end
`else
   always_comb begin
      t_on_s = 32'(T_NOTA);
   end
`endif

   // Next-state, counter, index and registered-output computation.
   always_comb begin
      estado_d    = estado_q;
      notas_d     = notas_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
`ifdef SECUENCIADOR_TEMPO_EN
      tempo_d     = tempo_q;
`endif
      idx_sig_s   = idx_q + 4'd1;
      fin_nota_s  = (cnt_q == CW'(t_on_s - 32'd1));
      fin_pausa_s = (cnt_q == CW'(T_PAUSA - 1));

      if ((estado_q != REPOSO) && abortar) begin
         // Abort: back to idle, index held, no completion pulse.
         estado_d = REPOSO;
         cnt_d    = '0;
      end else begin
         case (estado_q)
            REPOSO: begin
               if (inicio && !abortar) begin
                  estado_d = SOLICITA;
               end else begin
                  estado_d = REPOSO;
               end
            end
            SOLICITA: begin
               estado_d = CAPTURA;
               idx_d    = 4'd0;
            end
            CAPTURA: begin
               // Source presents the bus during this cycle; freeze it here.
               notas_d = busNotas;
`ifdef SECUENCIADOR_TEMPO_EN
               tempo_d = tempo;
`endif
               cnt_d   = '0;
               if (slot_de(busNotas, 4'd0) == '0) begin
                  estado_d = FIN;
               end else begin
                  estado_d = SONAR;
               end
            end
            SONAR: begin
               if (fin_nota_s) begin
                  estado_d = PAUSA;
                  cnt_d    = '0;
               end else begin
                  cnt_d    = cnt_q + 1'b1;
               end
            end
            PAUSA: begin
               if (fin_pausa_s) begin
                  cnt_d = '0;
                  idx_d = idx_sig_s;
                  if ((idx_sig_s == 4'(NUM_NOTAS)) || (slot_de(notas_q, idx_sig_s) == '0)) begin
                     estado_d = FIN;
                  end else begin
                     estado_d = SONAR;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            FIN: begin
               estado_d = REPOSO;
            end
            default: begin
               estado_d = REPOSO;
               cnt_d    = '0;
            end
         endcase
      end

      // Outputs are decoded from the next state so they register in step with it.
      cargar_d  = (estado_d == SOLICITA);
      sonando_d = (estado_d == SONAR);
      ocupado_d = (estado_d != REPOSO);
      lista_d   = (estado_d == FIN);
      if (estado_d == SONAR) begin
         nota_d = slot_de(notas_d, idx_d);
      end else begin
         nota_d = '0;
      end
   end

   // State and output registers, cleared immediately by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado_q  <= REPOSO;
         notas_q   <= '0;
         cnt_q     <= '0;
         idx_q     <= 4'd0;
         cargar_q  <= 1'b0;
         nota_q    <= '0;
         sonando_q <= 1'b0;
         ocupado_q <= 1'b0;
         lista_q   <= 1'b0;
`ifdef SECUENCIADOR_TEMPO_EN
         tempo_q   <= 2'd0;
`endif
      end else begin
         estado_q  <= estado_d;
         notas_q   <= notas_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         cargar_q  <= cargar_d;
         nota_q    <= nota_d;
         sonando_q <= sonando_d;
         ocupado_q <= ocupado_d;
         lista_q   <= lista_d;
`ifdef SECUENCIADOR_TEMPO_EN
         tempo_q   <= tempo_d;
`endif
      end
   end

   assign cargarSecuencia = cargar_q;
   assign notaSalida      = nota_q;
   assign sonando         = sonando_q;
   assign indiceNota      = idx_q;
   assign ocupado         = ocupado_q;
   assign secuenciaLista  = lista_q;

endmodule

// File: tb/tb_secuenciador_notas.sv
// Testbench for secuenciador_notas with T_NOTA=4, T_PAUSA=2.
// Each scenario builds the expected per-cycle output trace into a scoreboard
// queue before starting the player, then pops one entry per clock and compares.
module tb_secuenciador_notas;

   localparam int T_PAUSA_TB = 2;

   typedef struct packed {
      logic       carg;
      logic [2:0] nota;
      logic       son;
      logic [3:0] idx;
      logic       ocu;
      logic       lista;
   } obs_t;

   logic        clk;
   logic        reset;
   logic        inicio;
   logic        abortar;
   logic [29:0] busNotas;
`ifdef SECUENCIADOR_TEMPO_EN
   logic [1:0]  tempo;
`endif
   logic        cargarSecuencia;
   logic [2:0]  notaSalida;
   logic        sonando;
   logic [3:0]  indiceNota;
   logic        ocupado;
   logic        secuenciaLista;

   obs_t        q[$];
   int          total;
   int          bad;
   logic [3:0]  exp_idx;

   secuenciador_notas #(
      .NUM_NOTAS(10), .ANCHO_NOTA(3), .T_NOTA(4), .T_PAUSA(T_PAUSA_TB)
   ) dut (
      .clk(clk),
      .reset(reset),
      .inicio(inicio),
      .abortar(abortar),
      .busNotas(busNotas),
`ifdef SECUENCIADOR_TEMPO_EN
      .tempo(tempo),
`endif
      .cargarSecuencia(cargarSecuencia),
      .notaSalida(notaSalida),
      .sonando(sonando),
      .indiceNota(indiceNota),
      .ocupado(ocupado),
      .secuenciaLista(secuenciaLista)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Expected trace starting with the cycle after the edge that samples inicio.
   // cut >= 0 replaces everything from that entry on with idle (abort case).
   task automatic gen_trace(input logic [29:0] bus, input int t_on, input int cut);
      obs_t e;
      int   i;
      logic [3:0] last;
      e = {1'b1, 3'd0, 1'b0, exp_idx, 1'b1, 1'b0}; q.push_back(e);
      e = {1'b0, 3'd0, 1'b0, 4'd0, 1'b1, 1'b0};    q.push_back(e);
      i = 0;
      while (i < 10) begin
         if (bus[3*i +: 3] == 3'd0) break;
         for (int c = 0; c < t_on; c++) begin
            e = {1'b0, bus[3*i +: 3], 1'b1, 4'(i), 1'b1, 1'b0}; q.push_back(e);
         end
         for (int c = 0; c < T_PAUSA_TB; c++) begin
            e = {1'b0, 3'd0, 1'b0, 4'(i), 1'b1, 1'b0}; q.push_back(e);
         end
         i++;
      end
      e = {1'b0, 3'd0, 1'b0, 4'(i), 1'b1, 1'b1}; q.push_back(e);
      e = {1'b0, 3'd0, 1'b0, 4'(i), 1'b0, 1'b0}; q.push_back(e);
      e = {1'b0, 3'd0, 1'b0, 4'(i), 1'b0, 1'b0}; q.push_back(e);
      exp_idx = 4'(i);
      if (cut >= 0) begin
         last = q[cut-1].idx;
         while (q.size() > cut) void'(q.pop_back());
         e = {1'b0, 3'd0, 1'b0, last, 1'b0, 1'b0};
         q.push_back(e);
         q.push_back(e);
         exp_idx = last;
      end
   endtask

   // Pops n entries, one per clock; drives inicio/abortar/bus pokes after a given entry.
   task automatic drain(input string name, input int n, input int ini_at, input int abo_at,
                        input int scramble_at);
      obs_t got;
      obs_t e;
      for (int j = 0; j < n; j++) begin
         @(posedge clk);
         #1;
         got = {cargarSecuencia, notaSalida, sonando, indiceNota, ocupado, secuenciaLista};
         e = q.pop_front();
         total++;
         if (got !== e) begin
            bad++;
            $display("FAIL %s[%0d]: got carg=%b nota=%0d son=%b idx=%0d ocu=%b lista=%b, want carg=%b nota=%0d son=%b idx=%0d ocu=%b lista=%b",
                     name, j, got.carg, got.nota, got.son, got.idx, got.ocu, got.lista,
                     e.carg, e.nota, e.son, e.idx, e.ocu, e.lista);
         end
         inicio  = (j == ini_at);
         abortar = (j == abo_at);
         if (j == scramble_at) busNotas = 30'h3FFF_FFFF;
      end
   endtask

   task automatic start_run();
      @(negedge clk);
      inicio = 1'b1;
   endtask

   task automatic test_reset();
      obs_t got;
      reset = 1'b1;
      #12;
      got = {cargarSecuencia, notaSalida, sonando, indiceNota, ocupado, secuenciaLista};
      total++;
      if (got !== 11'd0) begin
         bad++;
         $display("FAIL reset_values: got %b want %b", got, 11'd0);
      end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      got = {cargarSecuencia, notaSalida, sonando, indiceNota, ocupado, secuenciaLista};
      total++;
      if (got !== 11'd0) begin
         bad++;
         $display("FAIL idle_after_reset: got %b want %b", got, 11'd0);
      end
      exp_idx = 4'd0;
   endtask

   task automatic test_full();
      busNotas = 30'b111101111101111101111101111101;
      gen_trace(busNotas, 4, -1);
      start_run();
      drain("full", q.size(), -1, -1, -1);
   endtask

   task automatic test_early_term();
      busNotas = 30'b000_011_010;
      gen_trace(busNotas, 4, -1);
      start_run();
      drain("early", q.size(), -1, -1, 2);
   endtask

   task automatic test_empty();
      busNotas = 30'd0;
      gen_trace(busNotas, 4, -1);
      start_run();
      drain("empty", q.size(), -1, -1, -1);
   endtask

   task automatic test_abort();
      busNotas = 30'b111101111101111101111101111101;
      gen_trace(busNotas, 4, 22);
      start_run();
      drain("abort", q.size(), -1, 21, -1);
   endtask

   task automatic test_busy_inicio();
      busNotas = 30'b111101111101111101111101111101;
      gen_trace(busNotas, 4, -1);
      start_run();
      drain("busy", q.size(), 3, -1, -1);
   endtask

   task automatic test_reset_mid_note();
      obs_t got;
      busNotas = 30'b111101111101111101111101111101;
      gen_trace(busNotas, 4, -1);
      start_run();
      drain("pre_reset", 4, -1, -1, -1);
      q.delete();
      #3;
      reset = 1'b1;
      #1;
      got = {cargarSecuencia, notaSalida, sonando, indiceNota, ocupado, secuenciaLista};
      total++;
      if (got !== 11'd0) begin
         bad++;
         $display("FAIL async_reset_mid_note: got %b want %b", got, 11'd0);
      end
      @(negedge clk);
      reset = 1'b0;
      exp_idx = 4'd0;
      gen_trace(busNotas, 4, -1);
      start_run();
      drain("replay", q.size(), -1, -1, -1);
   endtask

`ifdef SECUENCIADOR_TEMPO_EN
   task automatic test_tempo();
      busNotas = 30'b000_011_010;
      tempo = 2'd1;
      gen_trace(busNotas, 2, -1);
      start_run();
      drain("tempo", q.size(), -1, -1, -1);
      tempo = 2'd0;
   endtask
`endif

   initial begin
      total    = 0;
      bad      = 0;
      inicio   = 1'b0;
      abortar  = 1'b0;
      busNotas = 30'd0;
      exp_idx  = 4'd0;
`ifdef SECUENCIADOR_TEMPO_EN
      tempo    = 2'd0;
`endif
      test_reset();
      test_full();
      test_early_term();
      test_empty();
      test_abort();
      test_busy_inicio();
      test_reset_mid_note();
`ifdef SECUENCIADOR_TEMPO_EN
      test_tempo();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
